// File: rtl/uart_line_pkg.sv
// Shared encodings for the UART line engine: FSM states, run modes,
// control characters and the lower-case range used for case folding.
package uart_line_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ECHO_WR,
        EMIT_RD,
        EMIT_WR,
        EMIT_CR,
        EMIT_LF
    } state_t;

    localparam logic [1:0] MODE_RAW   = 2'd0;
    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_LINE  = 2'd2;
    localparam logic [1:0] MODE_REV   = 2'd3;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] LC_LO    = 8'h61;
    localparam logic [7:0] LC_HI    = 8'h7A;
    localparam logic [7:0] FOLD_OFS = 8'h20;

    // Lower-case ASCII letters map to upper case; everything else passes.
    function automatic logic [7:0] fold_upper(input logic [7:0] c);
        return (c >= LC_LO && c <= LC_HI) ? (c - FOLD_OFS) : c;
    endfunction

endpackage

// File: rtl/uart_line_buf.sv
// Line buffer: simple dual-port RAM, one write port, registered read port
// with one cycle of latency. rdata holds until the next read is issued.
module uart_line_buf
    import uart_line_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; held between reads so the emitter can stall on full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_line_engine.sv
// UART line engine: pops RX FIFO bytes and pushes TX FIFO bytes in raw,
// upper-case, line or reversed-line mode. Line modes buffer a line with
// backspace editing and emit it on CR/LF followed by CR LF.
// Optional UART_LINE_STATS_EN adds rx/drop/line 16-bit wrap counters.
module uart_line_engine
    import uart_line_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LINE_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              rx_fifo_dvalid,
    input  logic [DATA_W-1:0] rx_rdata,
    output logic              rx_rden,
    input  logic              rx_fifo_overrun,
    input  logic              tx_fifo_full,
    input  logic              tx_fifo_overrun,
    output logic              tx_wten,
    output logic [DATA_W-1:0] tx_wdata,
`ifdef UART_LINE_STATS_EN
    output logic [15:0]       rx_count,
    output logic [15:0]       drop_count,
    output logic [15:0]       line_count,
`endif
    output logic              busy,
    output logic              line_ovf,
    output logic              err_sticky
);

    localparam int AW    = $clog2(LINE_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_DEPTH);

    state_t            state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [AW-1:0]     idx, idx_n;
    logic [1:0]        mode_q, mode_n, cur_mode;
    logic [DATA_W-1:0] byte_q, byte_n, echo_byte, buf_rdata;
    logic              ovf_n, rd_gap, buf_we, buf_re, rev, last_idx;
    logic [7:0]        rx_lo;

    assign rx_lo    = rx_rdata[7:0];
    // Mode is re-sampled only when a new line (or raw byte) starts.
    assign cur_mode = (count == '0) ? mode : mode_q;
    assign rev      = (mode_q == MODE_REV);
    assign last_idx = rev ? (idx == '0) : (idx == AW'(count - 1'b1));
    assign busy     = (state != IDLE) || (count != '0);

    // Echo byte, folded to upper case on the low 8 bits when requested.
    always_comb begin
        echo_byte = byte_q;
        if (mode_q == MODE_UPPER) echo_byte[7:0] = fold_upper(byte_q[7:0]);
    end

    // Next-state and output decode.
    always_comb begin
        state_n  = state;
        count_n  = count;
        idx_n    = idx;
        mode_n   = mode_q;
        byte_n   = byte_q;
        ovf_n    = line_ovf;
        rx_rden  = 1'b0;
        tx_wten  = 1'b0;
        tx_wdata = '0;
        buf_we   = 1'b0;
        buf_re   = 1'b0;
        case (state)
            IDLE: begin
                // rd_gap covers the cycle where dvalid may still be stale.
                if (rx_fifo_dvalid && !rd_gap) begin
                    rx_rden = 1'b1;
                    byte_n  = rx_rdata;
                    mode_n  = cur_mode;
                    if (cur_mode == MODE_RAW || cur_mode == MODE_UPPER) begin
                        state_n = ECHO_WR;
                    end else if (rx_lo == CH_CR || rx_lo == CH_LF) begin
                        if (count == '0) begin
                            state_n = EMIT_CR;
                        end else begin
                            state_n = EMIT_RD;
                            idx_n   = (cur_mode == MODE_REV) ? AW'(count - 1'b1) : '0;
                        end
                    end else if (rx_lo == CH_BS) begin
                        if (count != '0) count_n = count - 1'b1;
                    end else if (count != FULL_CNT) begin
                        buf_we  = 1'b1;
                        count_n = count + 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            ECHO_WR: begin
                tx_wdata = echo_byte;
                if (!tx_fifo_full) begin
                    tx_wten = 1'b1;
                    state_n = IDLE;
                end
            end
            EMIT_RD: begin
                buf_re  = 1'b1;
                state_n = EMIT_WR;
            end
            EMIT_WR: begin
                tx_wdata = buf_rdata;
                if (!tx_fifo_full) begin
                    tx_wten = 1'b1;
                    if (last_idx) begin
                        state_n = EMIT_CR;
                    end else begin
                        idx_n   = rev ? (idx - 1'b1) : (idx + 1'b1);
                        state_n = EMIT_RD;
                    end
                end
            end
            EMIT_CR: begin
                tx_wdata = DATA_W'(CH_CR);
                if (!tx_fifo_full) begin
                    tx_wten = 1'b1;
                    state_n = EMIT_LF;
                end
            end
            EMIT_LF: begin
                tx_wdata = DATA_W'(CH_LF);
                if (!tx_fifo_full) begin
                    tx_wten = 1'b1;
                    count_n = '0;
                    ovf_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM and line bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            idx      <= '0;
            mode_q   <= MODE_RAW;
            byte_q   <= '0;
            line_ovf <= 1'b0;
            rd_gap   <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            idx      <= idx_n;
            mode_q   <= mode_n;
            byte_q   <= byte_n;
            line_ovf <= ovf_n;
            rd_gap   <= rx_rden;
        end
    end

    // Overrun flags accumulate regardless of FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     err_sticky <= 1'b0;
        else if (rx_fifo_overrun || tx_fifo_overrun) err_sticky <= 1'b1;
    end

    uart_line_buf #(.DATA_W(DATA_W), .DEPTH(LINE_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr (count[AW-1:0]),
        .wdata (rx_rdata),
        .re    (buf_re),
        .raddr (idx),
        .rdata (buf_rdata)
    );

`ifdef UART_LINE_STATS_EN
    logic drop_evt, line_evt;
    assign drop_evt = rx_rden && cur_mode[1] && rx_lo != CH_CR && rx_lo != CH_LF
                      && rx_lo != CH_BS && count == FULL_CNT;
    assign line_evt = tx_wten && state == EMIT_LF;

    // Statistics counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count   <= '0;
            drop_count <= '0;
            line_count <= '0;
        end else begin
            if (rx_rden)  rx_count   <= rx_count + 16'd1;
            if (drop_evt) drop_count <= drop_count + 16'd1;
            if (line_evt) line_count <= line_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_line_engine.sv
// Bench for uart_line_engine (LINE_DEPTH=4): table vectors, hand-written
// corner sequences and randomized streams against a string-level model.
module tb_uart_line_engine;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       rx_fifo_dvalid, rx_rden, rx_fifo_overrun;
    logic [7:0] rx_rdata, tx_wdata;
    logic       tx_fifo_full, tx_fifo_overrun, tx_wten;
    logic       busy, line_ovf, err_sticky;
`ifdef UART_LINE_STATS_EN
    logic [15:0] rx_count, drop_count, line_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_line_engine #(.DATA_W(8), .LINE_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .rx_fifo_dvalid  (rx_fifo_dvalid),
        .rx_rdata        (rx_rdata),
        .rx_rden         (rx_rden),
        .rx_fifo_overrun (rx_fifo_overrun),
        .tx_fifo_full    (tx_fifo_full),
        .tx_fifo_overrun (tx_fifo_overrun),
        .tx_wten         (tx_wten),
        .tx_wdata        (tx_wdata),
`ifdef UART_LINE_STATS_EN
        .rx_count        (rx_count),
        .drop_count      (drop_count),
        .line_count      (line_count),
`endif
        .busy            (busy),
        .line_ovf        (line_ovf),
        .err_sticky      (err_sticky)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic chk_s(input string name, input string got, input string exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=[%s] want=[%s]", name, got, exp);
        end
    endtask

    function automatic string hx(input logic [7:0] b);
        return $sformatf("%02h", b);
    endfunction

    function automatic string hexs(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, hx(s[i])};
        return r;
    endfunction

    // Reference: what the TX FIFO should receive for an RX string in one mode.
    function automatic string model_hex(input logic [1:0] m, input string rx);
        logic [7:0] line[$];
        logic [7:0] c;
        string r = "";
        for (int i = 0; i < rx.len(); i++) begin
            c = rx[i];
            if (m == 2'd0) r = {r, hx(c)};
            else if (m == 2'd1) r = {r, hx((c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c)};
            else if (c == 8'h0D || c == 8'h0A) begin
                if (m == 2'd3) for (int j = line.size() - 1; j >= 0; j--) r = {r, hx(line[j])};
                else           for (int j = 0; j < line.size(); j++)      r = {r, hx(line[j])};
                r = {r, "0d0a"};
                line.delete();
            end else if (c == 8'h08) begin
                if (line.size() > 0) void'(line.pop_back());
            end else if (line.size() < DEPTH) line.push_back(c);
        end
        return r;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; rx_fifo_dvalid = 1'b0; rx_rdata = '0; tx_fifo_full = 1'b0;
        rx_fifo_overrun = 1'b0; tx_fifo_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Feed an RX string as a first-word-fall-through FIFO, capture TX and
    // count protocol violations. full_kind: 0 never, 1 random, 2 ten-cycle
    // window after the first push.
    task automatic run_stream(input logic [1:0] m, input string rx, input int full_kind,
                              input bit wait_idle, output string got, output int gap_v,
                              output int lat_v, output int full_v, output int ovf_lf,
                              output int tmo);
        int idx = 0, cyc = 0, last_rd = -100, win = -100, n_got = 0;
        bit done = 0;
        got = ""; gap_v = 0; lat_v = 0; full_v = 0; ovf_lf = -1; tmo = 0;
        mode = m;
        while (!done) begin
            @(posedge clk); #1;
            rx_fifo_dvalid = (idx < rx.len());
            rx_rdata       = rx_fifo_dvalid ? rx[idx] : 8'h00;
            case (full_kind)
                1:       tx_fifo_full = ($urandom_range(0, 2) == 0);
                2:       tx_fifo_full = (cyc >= win && cyc < win + 10);
                default: tx_fifo_full = 1'b0;
            endcase
            @(negedge clk);
            if (rx_rden) begin
                if (cyc - last_rd < 2 || !rx_fifo_dvalid) gap_v++;
                last_rd = cyc;
                idx++;
            end
            if (m < 2'd2 && last_rd == cyc - 1 && !tx_fifo_full && !tx_wten) lat_v++;
            if (tx_wten) begin
                if (tx_fifo_full) full_v++;
                got = {got, hx(tx_wdata)};
                n_got++;
                if (tx_wdata == 8'h0A) ovf_lf = int'(line_ovf);
                if (full_kind == 2 && n_got == 1) win = cyc + 1;
            end
            cyc++;
            if (idx >= rx.len() && cyc > last_rd + 1 && (!wait_idle || !busy)) done = 1;
            if (cyc > 3000) begin tmo = 1; done = 1; end
        end
        rx_fifo_dvalid = 1'b0;
        tx_fifo_full   = 1'b0;
    endtask

    typedef struct {
        logic [1:0] m;
        string      rx;
        string      exp;
        int         fk;
    } vec_t;

    vec_t  tbl[7];
    string got, got2, rx, name;
    int    gap_v, lat_v, full_v, ovf_lf, tmo;
    logic [7:0] c;

    initial begin
        tbl[0] = '{2'd0, "aZ",                   "aZ",                  0};
        tbl[1] = '{2'd1, "a{z",                  "A{Z",                 2};
        tbl[2] = '{2'd2, "abX\010c\015",         "abc\015\012",         0};
        tbl[3] = '{2'd2, "\012",                 "\015\012",            0};
        tbl[4] = '{2'd3, "1234\012",             "4321\015\012",        0};
        tbl[5] = '{2'd3, "ab\010\010\015",       "\015\012",            1};
        tbl[6] = '{2'd1, "AzQ`{m",               "AZQ`{M",              1};

        mode = 2'd0;
        do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_rden", int'(rx_rden), 0);
        chk("rst_wten", int'(tx_wten), 0);
        chk("rst_wdata", int'(tx_wdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(line_ovf), 0);
        chk("rst_err", int'(err_sticky), 0);
        do_reset();

        // Table vectors
        foreach (tbl[i]) begin
            run_stream(tbl[i].m, tbl[i].rx, tbl[i].fk, 1'b1, got, gap_v, lat_v, full_v, ovf_lf, tmo);
            name = $sformatf("vec%0d", i);
            chk_s({name, "_tx"}, got, hexs(tbl[i].exp));
            chk({name, "_rden_gap"}, gap_v, 0);
            chk({name, "_latency"}, lat_v, 0);
            chk({name, "_wr_full"}, full_v, 0);
            chk({name, "_timeout"}, tmo, 0);
        end

        // Overflow on a 4-entry line
        do_reset();
        run_stream(2'd2, "abcdef", 0, 1'b0, got, gap_v, lat_v, full_v, ovf_lf, tmo);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ovf_mid_flag", int'(line_ovf), 1);
        chk("ovf_mid_busy", int'(busy), 1);
        run_stream(2'd2, "\015", 1, 1'b1, got2, gap_v, lat_v, full_v, ovf_lf, tmo);
        chk_s("ovf_tx", {got, got2}, hexs("abcd\015\012"));
        chk("ovf_at_lf", ovf_lf, 1);
        chk("ovf_after", int'(line_ovf), 0);
        chk("ovf_timeout", tmo, 0);
`ifdef UART_LINE_STATS_EN
        chk("stat_drop", int'(drop_count), 2);
        chk("stat_rx", int'(rx_count), 7);
        chk("stat_line", int'(line_count), 1);
`endif

        // Mode change mid-line applies only after the line ends
        run_stream(2'd2, "ab", 0, 1'b0, got, gap_v, lat_v, full_v, ovf_lf, tmo);
        run_stream(2'd0, "c\015", 0, 1'b1, got2, gap_v, lat_v, full_v, ovf_lf, tmo);
        chk_s("modechg_line", {got, got2}, hexs("abc\015\012"));
        run_stream(2'd0, "x\015", 0, 1'b1, got, gap_v, lat_v, full_v, ovf_lf, tmo);
        chk_s("modechg_raw", got, hexs("x\015"));

        // Reset mid-line discards the partial line
        run_stream(2'd2, "ab", 0, 1'b0, got, gap_v, lat_v, full_v, ovf_lf, tmo);
        chk_s("rstmid_no_tx", got, "");
        chk("rstmid_busy_pre", int'(busy), 1);
        do_reset();
        @(negedge clk);
        chk("rstmid_busy_post", int'(busy), 0);
        run_stream(2'd2, "\012", 0, 1'b1, got, gap_v, lat_v, full_v, ovf_lf, tmo);
        chk_s("rstmid_empty_line", got, hexs("\015\012"));

        // Overrun stickiness
        @(posedge clk); #1 rx_fifo_overrun = 1'b1;
        @(negedge clk);
        chk("err_same_cycle", int'(err_sticky), 0);
        @(posedge clk); #1 rx_fifo_overrun = 1'b0;
        @(negedge clk);
        chk("err_rx_set", int'(err_sticky), 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("err_rx_hold", int'(err_sticky), 1);
        do_reset();
        @(negedge clk);
        chk("err_rst_clear", int'(err_sticky), 0);
        @(posedge clk); #1 tx_fifo_overrun = 1'b1;
        @(posedge clk); #1 tx_fifo_overrun = 1'b0;
        @(negedge clk);
        chk("err_tx_set", int'(err_sticky), 1);

        // Randomized streams, each left with an empty line buffer
        for (int r = 0; r < 25; r++) begin
            logic [1:0] m;
            m  = 2'($urandom_range(0, 3));
            rx = "";
            for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
                case ($urandom_range(0, 9))
                    0:       c = 8'h08;
                    1:       c = 8'h0D;
                    2:       c = 8'h0A;
                    3:       c = 8'h7B;
                    4:       c = 8'h60;
                    default: c = 8'($urandom_range(8'h30, 8'h7A));
                endcase
                rx = $sformatf("%s%c", rx, c);
            end
            if (m >= 2'd2) rx = $sformatf("%s%c", rx, 8'h0D);
            run_stream(m, rx, 1, 1'b1, got, gap_v, lat_v, full_v, ovf_lf, tmo);
            name = $sformatf("rnd%0d_m%0d", r, m);
            chk_s({name, "_tx"}, got, model_hex(m, rx));
            chk({name, "_proto"}, gap_v + lat_v + full_v + tmo, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
